// File: rtl/ledger_pkg.sv
// Shared types and defaults for the balance ledger.
package ledger_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} ledger_state_t;

  localparam int LEDGER_WIDTH       = 8;
  localparam int LEDGER_STEP        = 1;
  localparam int LEDGER_HOLD_CYCLES = 50_000_000;

  // BCD digit width and number of digits carried on bcd_digits.
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 3;
endpackage

// File: rtl/ledger_bcd.sv
// Sequential shift-add (double dabble) binary-to-BCD converter.
// start loads a new value (restarting any conversion in progress); the
// result is latched WIDTH+1 edges after start, when busy falls and done rises.
module ledger_bcd
  import ledger_pkg::*;
#(
  parameter int WIDTH = LEDGER_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  bin,
  output logic                              busy,
  output logic                              done,
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd
);
  localparam int BW = BCD_DIGIT_W * BCD_DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [SW-1:0] sreg, step;
  logic [CW-1:0] cnt;

  // One dabble step: add 3 to every digit >= 5, then shift left by one.
  always_comb begin
    step = sreg;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (step[WIDTH + BCD_DIGIT_W*d +: BCD_DIGIT_W] >= 4'd5)
        step[WIDTH + BCD_DIGIT_W*d +: BCD_DIGIT_W] =
          step[WIDTH + BCD_DIGIT_W*d +: BCD_DIGIT_W] + 4'd3;
    end
    step = step << 1;
  end

  // Load on start, shift WIDTH times, then latch the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b1;
      bcd  <= '0;
    end else if (start) begin
      sreg <= {{BW{1'b0}}, bin};
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (cnt == CW'(WIDTH)) begin
        bcd  <= sreg[SW-1 -: BW];
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        sreg <= step;
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/balance_ledger.sv
// Balance ledger: applies deposit/withdraw pulses to a saturating balance
// and stretches refusals into deny_led. Optional BCD readout under
// LEDGER_BCD_EN.
module balance_ledger
  import ledger_pkg::*;
#(
  parameter int WIDTH       = LEDGER_WIDTH,
  parameter int STEP        = LEDGER_STEP,
  parameter int MAX_BAL     = 2**WIDTH - 1,
  parameter int HOLD_CYCLES = LEDGER_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_up,
  input  logic             count_down,
  output logic [WIDTH-1:0] balance,
  output logic             accepted,
  output logic             denied,
  output logic             overflow,
  output logic             deny_led,
  output logic             empty,
`ifdef LEDGER_BCD_EN
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd_digits,
  output logic             bcd_valid,
`endif
  output logic             full
);
  localparam int W1  = WIDTH + 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [WIDTH:0]   STEP_X    = W1'(STEP);
  localparam logic [WIDTH:0]   MAX_X     = W1'(MAX_BAL);
  localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);
  localparam logic [HCW-1:0]   HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  logic [WIDTH:0]   bal_x;
  logic [WIDTH-1:0] bal_nxt;
  logic             acc_nxt, den_nxt, ovf_nxt, refuse;
  ledger_state_t    state, state_nxt;
  logic [HCW-1:0]   hold_cnt, hold_nxt;

  // Limits are evaluated one bit wider so balance+STEP cannot wrap.
  assign bal_x  = {1'b0, balance};
  assign empty  = bal_x < STEP_X;
  assign full   = (bal_x + STEP_X) > MAX_X;
  assign refuse = den_nxt | ovf_nxt;

  // Request decode: simultaneous up and down cancel with no pulse.
  always_comb begin
    bal_nxt = balance;
    acc_nxt = 1'b0;
    den_nxt = 1'b0;
    ovf_nxt = 1'b0;
    case ({count_up, count_down})
      2'b10: if (full)  ovf_nxt = 1'b1;
             else begin bal_nxt = balance + STEP_N; acc_nxt = 1'b1; end
      2'b01: if (empty) den_nxt = 1'b1;
             else begin bal_nxt = balance - STEP_N; acc_nxt = 1'b1; end
      default: ;
    endcase
  end

  // Balance and one-cycle result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balance  <= '0;
      accepted <= 1'b0;
      denied   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      balance  <= bal_nxt;
      accepted <= acc_nxt;
      denied   <= den_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Indicator FSM state and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Any refusal (re)loads the stretch; HOLD ends once the count runs out.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: if (refuse) begin state_nxt = HOLD; hold_nxt = HOLD_LOAD; end
      HOLD: if (refuse)              hold_nxt  = HOLD_LOAD;
            else if (hold_cnt == '0) state_nxt = IDLE;
            else                     hold_nxt  = hold_cnt - 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign deny_led = (state == HOLD);

`ifdef LEDGER_BCD_EN
  logic bcd_busy, bcd_done;

  // Restart the converter on the same edge that changes balance.
  ledger_bcd #(.WIDTH(WIDTH)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bal_nxt != balance),
    .bin   (bal_nxt),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_digits)
  );

  assign bcd_valid = bcd_done & ~bcd_busy;
`endif
endmodule

// File: tb/tb_balance_ledger.sv
// Randomized bench for balance_ledger: two instances (MAX_BAL=5 and 255,
// HOLD_CYCLES=4) checked every cycle against a behavioural ledger model.
module tb_balance_ledger;
  localparam int HOLD = 4;
  localparam int W    = 8;
  int MAXB [2] = '{5, 255};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] up = '0, dn = '0;
  logic [W-1:0] bal [2];
  logic acc [2], den [2], ovf [2], led [2], emp [2], ful [2];
`ifdef LEDGER_BCD_EN
  logic [11:0] dig [2];
  logic        bv  [2];
`endif

  int n_cmp = 0, n_err = 0;
  int m_bal [2], m_led [2], m_left [2];
  bit e_acc [2], e_den [2], e_ovf [2];

  always #5 clk = ~clk;

  balance_ledger #(.WIDTH(W), .STEP(1), .MAX_BAL(5), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .reset(reset), .count_up(up[0]), .count_down(dn[0]),
    .balance(bal[0]), .accepted(acc[0]), .denied(den[0]), .overflow(ovf[0]),
    .deny_led(led[0]), .empty(emp[0]),
`ifdef LEDGER_BCD_EN
    .bcd_digits(dig[0]), .bcd_valid(bv[0]),
`endif
    .full(ful[0]));

  balance_ledger #(.WIDTH(W), .STEP(1), .MAX_BAL(255), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .reset(reset), .count_up(up[1]), .count_down(dn[1]),
    .balance(bal[1]), .accepted(acc[1]), .denied(den[1]), .overflow(ovf[1]),
    .deny_led(led[1]), .empty(emp[1]),
`ifdef LEDGER_BCD_EN
    .bcd_digits(dig[1]), .bcd_valid(bv[1]),
`endif
    .full(ful[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bal[i] = 0; m_led[i] = 0; m_left[i] = 0;
      e_acc[i] = 0; e_den[i] = 0; e_ovf[i] = 0;
    end
  endtask

  // Ledger rules: saturating balance, refusals stretch the LED for HOLD
  // cycles from the refusal, a changed balance costs W+1 cycles of BCD.
  task automatic model_step(input bit [1:0] u, input bit [1:0] d);
    for (int i = 0; i < 2; i++) begin
      int old;
      old = m_bal[i];
      e_acc[i] = 0; e_den[i] = 0; e_ovf[i] = 0;
      if (u[i] && !d[i]) begin
        if (m_bal[i] + 1 > MAXB[i]) e_ovf[i] = 1;
        else begin m_bal[i]++; e_acc[i] = 1; end
      end else if (d[i] && !u[i]) begin
        if (m_bal[i] < 1) e_den[i] = 1;
        else begin m_bal[i]--; e_acc[i] = 1; end
      end
      if (e_den[i] || e_ovf[i]) m_led[i] = HOLD;
      else if (m_led[i] > 0)    m_led[i]--;
      if (m_bal[i] != old)      m_left[i] = W + 1;
      else if (m_left[i] > 0)   m_left[i]--;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("balance%0d", i),  bal[i], m_bal[i]);
      chk($sformatf("accepted%0d", i), acc[i], e_acc[i]);
      chk($sformatf("denied%0d", i),   den[i], e_den[i]);
      chk($sformatf("overflow%0d", i), ovf[i], e_ovf[i]);
      chk($sformatf("deny_led%0d", i), led[i], m_led[i] > 0);
      chk($sformatf("empty%0d", i),    emp[i], m_bal[i] < 1);
      chk($sformatf("full%0d", i),     ful[i], m_bal[i] + 1 > MAXB[i]);
`ifdef LEDGER_BCD_EN
      chk($sformatf("bcd_valid%0d", i), bv[i], m_left[i] == 0);
      if (m_left[i] == 0) chk($sformatf("bcd_digits%0d", i), dig[i], to_bcd(m_bal[i]));
`endif
    end
  endtask

  // Inputs applied well before the edge; outputs sampled 1ns after it.
  task automatic cycle(input bit [1:0] u, input bit [1:0] d);
    up = u; dn = d;
    @(posedge clk);
    model_step(u, d);
    #1;
    check_all();
  endtask

  // Assert reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    up = '0; dn = '0;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Three deposits on both instances.
    repeat (3) begin cycle(2'b11, 2'b00); cycle(2'b00, 2'b00); end

    // Withdraw at zero: denied pulse, LED stretched HOLD cycles.
    do_reset();
    cycle(2'b00, 2'b11);
    repeat (6) cycle(2'b00, 2'b00);

    // Overflow at MAX_BAL=5, second refusal two cycles later.
    do_reset();
    repeat (5) cycle(2'b01, 2'b00);
    cycle(2'b01, 2'b00);
    cycle(2'b00, 2'b00);
    cycle(2'b01, 2'b00);
    repeat (8) cycle(2'b00, 2'b00);

    // Simultaneous up/down at balance 2.
    do_reset();
    repeat (2) cycle(2'b11, 2'b00);
    cycle(2'b11, 2'b11);
    cycle(2'b00, 2'b00);

    // Async reset mid-HOLD (instance a) with instance b at 7.
    do_reset();
    repeat (7) cycle(2'b11, 2'b00);
    #2;
    do_reset();

    // Drive instance b to 255, let the BCD settle, then overflow it.
    repeat (255) cycle(2'b10, 2'b00);
    repeat (11) cycle(2'b00, 2'b00);
    cycle(2'b10, 2'b00);
    repeat (5) cycle(2'b00, 2'b00);

    // Random traffic from a fresh start.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit [1:0] u, d;
      for (int i = 0; i < 2; i++) begin
        u[i] = ($urandom_range(0, 2) == 0);
        d[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) != 0) begin u = '0; d = '0; end
      cycle(u, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
